gsau_wb_buffer: RTL and testbench
=================================

// Module: gsau_wb_buffer
// PURPOSE
//  Writeback buffer directly downstream of the GSAU. Queues partial-sum vectors (psum + wbdst) produced
//  by the GSAU and drains them in order to a vector-register-file write port. Also notifies the
//  scoreboard when each writeback commits. Applies backpressure to the GSAU via output_ready.
// PARAMETERS
//  DEPTH   4    entries; power of 2, >=2
//  VW      512  vector width in bits (= vreg_t width)
//  RW      8    destination register index width
// PORTS
//  CLK           in   1       clock, all state on rising edge
//  RST           in   1       synchronous, active-high reset
//  wb_valid      in   1       GSAU: psum/wbdst valid (push request)
//  psum          in   VW      GSAU: partial-sum vector
//  wbdst         in   RW      GSAU: destination vreg index
//  output_ready  out  1       to GSAU: buffer can accept (= !full)
//  rf_wen        out  1       RF write request (head valid)
//  rf_wdata      out  VW      RF write data (head psum)
//  rf_wdst       out  RW      RF write index (head wbdst)
//  rf_wready     in   1       RF accepts write this cycle
//  sb_done       out  1       1-cycle pulse: writeback committed
//  sb_vdst       out  RW      register index that committed
//  count         out  log2(DEPTH)+1  occupancy
//  ovf_err       out  1       sticky: push attempted while full
// BEHAVIOUR
//  - Reset (RST=1 at edge): rd/wr pointers, count, sb_done, sb_vdst, ovf_err -> 0; all entries discarded,
//    including mid-drain. Thus output_ready=1, rf_wen=0 in the cycle after reset. rf_wdata/rf_wdst don't-care while rf_wen=0.
//  - Push: wb_valid && output_ready -> write {psum,wbdst} at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//  - Pop: rf_wen && rf_wready -> rd_ptr++ (wraps); next cycle sb_done=1, sb_vdst=popped wbdst.
//  - Latency: pushed entry appears on rf_* the cycle after push when buffer was empty (bypass off).
//  - rf_wen = (count!=0); rf_wdata/rf_wdst held stable while rf_wen && !rf_wready. Strict FIFO order.
//  - output_ready = (count!=DEPTH), from registered count only; no push-into-full even when pop in same cycle.
//  - Simultaneous push+pop (not full, not empty): count unchanged, both pointers advance.
//  - wb_valid while full: push dropped, state unchanged, ovf_err<=1 (cleared only by RST).
//  - No state machine beyond FIFO; count is the sole occupancy state, empty/full decoded from it.
// CONFIGURATION
//  - WB_BYPASS_EN defined: when count==0 and wb_valid, input drives rf_* combinationally (rf_wen=1);
//    if rf_wready same cycle, entry is not stored (count stays 0), sb_done next cycle; else stored normally.
//  - Undefined: no combinational path from GSAU inputs to rf_*; minimum latency 1 cycle.
// STRUCTURE
//  - sys_arr_pkg: WB_DEPTH, wb_entry_t {vreg_t psum; logic [7:0] dst}; reuse vreg_t from vector_pkg.
//  - One sub-module: gsau_wb_fifo (storage array, pointers, count, full/empty); top adds bypass, sb, ovf logic.
// TESTING
//  1 Reset: RST 2 cycles -> output_ready=1, rf_wen=0, count=0, sb_done=0, ovf_err=0.
//  2 Single: push psum=0xA5.., dst=3, rf_wready=1 -> rf_wen next cycle w/ dst 3; sb_done+sb_vdst=3 one cycle later.
//  3 Fill: rf_wready=0, push 4 (dst 1..4) -> count=4, output_ready=0; 5th push -> dropped, ovf_err=1;
//    release rf_wready -> writes dst 1,2,3,4 in order, count back to 0.
//  4 Stream: push every cycle + rf_wready=1 with DEPTH wraps x3 -> order preserved, count<=1, no ovf.
//  5 Reset mid-drain: 3 queued, RST at cycle 2 of drain -> rf_wen=0 next cycle, no further sb_done.
//  6 WB_BYPASS_EN: empty, push dst=7 with rf_wready=1 -> rf_wen & dst 7 same cycle, count stays 0.

Source files
------------

// File: rtl/gsau_wb_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gsau_wb_buffer_pkg
// Description : Shared widths, entry type and sizing helper for the GSAU
//               writeback buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package gsau_wb_buffer_pkg;

    localparam int WB_DEPTH = 4;
    localparam int VREG_W   = 512;
    localparam int VDST_W   = 8;

    typedef logic [VREG_W-1:0] vreg_t;

    typedef struct packed {
        vreg_t             psum;
        logic [VDST_W-1:0] dst;
    } wb_entry_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gsau_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gsau_wb_fifo
// Description : Storage array, wrapping read/write pointers and occupancy
//               count for the writeback buffer; empty/full decoded from count.
// Revision    : 1.0 - initial release
// ============================================================================
module gsau_wb_fifo
    import gsau_wb_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int W     = VREG_W + VDST_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Payload storage is never reset; count alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/gsau_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : gsau_wb_buffer
// Description : In-order writeback queue between the GSAU and a vector RF
//               write port, with scoreboard commit pulse and sticky overflow.
//               Optional macro WB_BYPASS_EN forwards into an empty buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module gsau_wb_buffer
    import gsau_wb_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int VW    = VREG_W,
    parameter int RW    = VDST_W
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          wb_valid,
    input  logic [VW-1:0]                 psum,
    input  logic [RW-1:0]                 wbdst,
    output logic                          output_ready,
    output logic                          rf_wen,
    output logic [VW-1:0]                 rf_wdata,
    output logic [RW-1:0]                 rf_wdst,
    input  logic                          rf_wready,
    output logic                          sb_done,
    output logic [RW-1:0]                 sb_vdst,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          ovf_err
);

    logic [VW+RW-1:0] head;
    logic [VW-1:0]    head_psum;
    logic [RW-1:0]    head_dst;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             commit;

    gsau_wb_fifo #(
        .DEPTH (DEPTH),
        .W     (VW + RW)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({psum, wbdst}),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_psum, head_dst} = head;

    // Readiness comes from registered occupancy only, so a pop in the same
    // cycle never makes room for a push into a full buffer.
    assign output_ready = !fifo_full;

`ifdef WB_BYPASS_EN
    logic bypass;

    assign bypass    = fifo_empty && wb_valid;
    assign rf_wen    = !fifo_empty || wb_valid;
    assign rf_wdata  = bypass ? psum  : head_psum;
    assign rf_wdst   = bypass ? wbdst : head_dst;
    // A forwarded entry the RF takes immediately never occupies a slot.
    assign fifo_push = wb_valid && !fifo_full && !(bypass && rf_wready);
`else
    assign rf_wen    = !fifo_empty;
    assign rf_wdata  = head_psum;
    assign rf_wdst   = head_dst;
    assign fifo_push = wb_valid && !fifo_full;
`endif

    assign commit   = rf_wen && rf_wready;
    assign fifo_pop = commit && !fifo_empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sb_done <= 1'b0;
            sb_vdst <= '0;
            ovf_err <= 1'b0;
        end else begin
            sb_done <= commit;
            if (commit) begin
                sb_vdst <= rf_wdst;
            end
            if (wb_valid && fifo_full) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gsau_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gsau_wb_buffer
// Description : Directed self-checking bench for gsau_wb_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gsau_wb_buffer;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         wb_valid = 1'b0;
    logic [511:0] psum = '0;
    logic [7:0]   wbdst = '0;
    logic         output_ready;
    logic         rf_wen;
    logic [511:0] rf_wdata;
    logic [7:0]   rf_wdst;
    logic         rf_wready = 1'b0;
    logic         sb_done;
    logic [7:0]   sb_vdst;
    logic [2:0]   count;
    logic         ovf_err;

    int n_tests = 0;
    int n_fail  = 0;

    gsau_wb_buffer dut (
        .CLK          (CLK),
        .RST          (RST),
        .wb_valid     (wb_valid),
        .psum         (psum),
        .wbdst        (wbdst),
        .output_ready (output_ready),
        .rf_wen       (rf_wen),
        .rf_wdata     (rf_wdata),
        .rf_wdst      (rf_wdst),
        .rf_wready    (rf_wready),
        .sb_done      (sb_done),
        .sb_vdst      (sb_vdst),
        .count        (count),
        .ovf_err      (ovf_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       ordy;
        logic       wen;
        logic [7:0] wdst;
        logic [2:0] cnt;
        logic       sb;
        logic [7:0] sbv;
        logic       ovf;
    } vec_t;

    vec_t tbl[15];

    // dst 3 maps to the 0xA5A5... pattern
    function automatic logic [511:0] pat(input logic [7:0] d);
        logic [7:0] b;
        b = d ^ 8'hA6;
        return {64{b}};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked just after.
    task automatic step;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic rdy);
        wb_valid  = v;
        wbdst     = d;
        psum      = pat(d);
        rf_wready = rdy;
        #1;
    endtask

    task automatic do_reset;
        drive(1'b0, 8'd0, 1'b0);
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        #1;
    endtask

    logic [7:0] q[$];
    logic       exp_sb;
    logic [7:0] exp_sbv;

    initial begin
        tbl[0]  = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0, 8'd0, 1'b0};
        tbl[1]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd3, 3'd1, 1'b0, 8'd0, 1'b0};
        tbl[2]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b1, 8'd3, 1'b0};
        tbl[3]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0, 8'd3, 1'b0};
        tbl[4]  = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0, 8'd3, 1'b0};
        tbl[5]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 8'd1, 3'd1, 1'b0, 8'd3, 1'b0};
        tbl[6]  = '{1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 8'd1, 3'd2, 1'b0, 8'd3, 1'b0};
        tbl[7]  = '{1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 8'd1, 3'd3, 1'b0, 8'd3, 1'b0};
        tbl[8]  = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 8'd1, 3'd4, 1'b0, 8'd3, 1'b0};
        tbl[9]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd1, 3'd4, 1'b0, 8'd3, 1'b1};
        tbl[10] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd2, 3'd3, 1'b1, 8'd1, 1'b1};
        tbl[11] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd3, 3'd2, 1'b1, 8'd2, 1'b1};
        tbl[12] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd4, 3'd1, 1'b1, 8'd3, 1'b1};
        tbl[13] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd0, 1'b1, 8'd4, 1'b1};
        tbl[14] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0, 8'd4, 1'b1};

        @(negedge CLK);
        do_reset();
        chk("reset output_ready", 512'(output_ready), 512'd1);
        chk("reset rf_wen",       512'(rf_wen),       512'd0);
        chk("reset count",        512'(count),        512'd0);
        chk("reset sb_done",      512'(sb_done),      512'd0);
        chk("reset ovf_err",      512'(ovf_err),      512'd0);

`ifndef WB_BYPASS_EN
        // Single push/commit, then fill, overflow and in-order drain.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].rdy);
            chk($sformatf("vec%0d output_ready", i), 512'(output_ready), 512'(tbl[i].ordy));
            chk($sformatf("vec%0d rf_wen", i),       512'(rf_wen),       512'(tbl[i].wen));
            chk($sformatf("vec%0d count", i),        512'(count),        512'(tbl[i].cnt));
            chk($sformatf("vec%0d sb_done", i),      512'(sb_done),      512'(tbl[i].sb));
            chk($sformatf("vec%0d sb_vdst", i),      512'(sb_vdst),      512'(tbl[i].sbv));
            chk($sformatf("vec%0d ovf_err", i),      512'(ovf_err),      512'(tbl[i].ovf));
            if (tbl[i].wen) begin
                chk($sformatf("vec%0d rf_wdst", i),  512'(rf_wdst),      512'(tbl[i].wdst));
                chk($sformatf("vec%0d rf_wdata", i), rf_wdata,           pat(tbl[i].wdst));
            end
            step();
        end

        // Streaming push+pop across three pointer wraps.
        do_reset();
        q.delete();
        exp_sb  = 1'b0;
        exp_sbv = 8'd0;
        for (int k = 0; k < 14; k++) begin
            drive(k < 12, 8'(k + 10), 1'b1);
            chk($sformatf("stream%0d rf_wen", k),       512'(rf_wen),       512'(q.size() != 0));
            chk($sformatf("stream%0d output_ready", k), 512'(output_ready), 512'd1);
            chk($sformatf("stream%0d count", k),        512'(count),        512'(q.size()));
            chk($sformatf("stream%0d sb_done", k),      512'(sb_done),      512'(exp_sb));
            chk($sformatf("stream%0d sb_vdst", k),      512'(sb_vdst),      512'(exp_sbv));
            if (q.size() != 0) begin
                chk($sformatf("stream%0d rf_wdst", k),  512'(rf_wdst),      512'(q[0]));
                chk($sformatf("stream%0d rf_wdata", k), rf_wdata,           pat(q[0]));
            end
            exp_sb = (q.size() != 0);
            if (exp_sb) begin
                exp_sbv = q.pop_front();
            end
            if (k < 12) begin
                q.push_back(8'(k + 10));
            end
            step();
        end
        chk("stream ovf_err", 512'(ovf_err), 512'd0);

        // Reset lands on the second drain cycle of three queued entries.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'(k + 20), 1'b0);
            step();
        end
        drive(1'b0, 8'd0, 1'b1);
        chk("middrain count", 512'(count), 512'd3);
        step();
        chk("middrain first rf_wdst", 512'(rf_wdst), 512'd21);
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        chk("middrain rf_wen after reset", 512'(rf_wen),  512'd0);
        chk("middrain count after reset",  512'(count),   512'd0);
        chk("middrain sb_done after reset", 512'(sb_done), 512'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("middrain quiet%0d sb_done", k), 512'(sb_done), 512'd0);
            chk($sformatf("middrain quiet%0d rf_wen", k),  512'(rf_wen),  512'd0);
        end
`else
        // Forwarding into an empty buffer, taken and not taken.
        do_reset();
        drive(1'b1, 8'd7, 1'b1);
        chk("bypass rf_wen",   512'(rf_wen),   512'd1);
        chk("bypass rf_wdst",  512'(rf_wdst),  512'd7);
        chk("bypass rf_wdata", rf_wdata,       pat(8'd7));
        step();
        drive(1'b0, 8'd0, 1'b0);
        chk("bypass count",   512'(count),   512'd0);
        chk("bypass sb_done", 512'(sb_done), 512'd1);
        chk("bypass sb_vdst", 512'(sb_vdst), 512'd7);
        chk("bypass rf_wen idle", 512'(rf_wen), 512'd0);
        drive(1'b1, 8'd9, 1'b0);
        chk("bypass stall rf_wdst", 512'(rf_wdst), 512'd9);
        step();
        drive(1'b0, 8'd0, 1'b1);
        chk("bypass stored count", 512'(count),   512'd1);
        chk("bypass stored wdst",  512'(rf_wdst), 512'd9);
        chk("bypass stored sb",    512'(sb_done), 512'd0);
        step();
        chk("bypass drained count", 512'(count),   512'd0);
        chk("bypass drained sb",    512'(sb_done), 512'd1);
        chk("bypass drained sbv",   512'(sb_vdst), 512'd9);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
